mpu_rsp_fifo: RTL and testbench

MPU_RSP_FIFO -- requirements
Module: mpu_rsp_fifo

---
 rtl/mpu_pkg.sv | 39 +++
 rtl/mpu_rsp_fifo_mem.sv | 39 +++
 rtl/mpu_rsp_fifo.sv | 167 ++++++++++++++++
 tb/tb_mpu_rsp_fifo.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mpu_pkg
//  Purpose  : Shared MPU types. Holds the TileLink D-channel beat structure
//             and the TL-D opcode constants used by response-path blocks.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package mpu_pkg;

  localparam int unsigned TL_DW   = 32;  // data bus width
  localparam int unsigned TL_SRCW = 8;   // source id width

  // TL-D opcodes
  localparam logic [2:0] TL_D_ACCESS_ACK      = 3'h0;
  localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'h1;
  localparam logic [2:0] TL_D_HINT_ACK        = 3'h2;
  localparam logic [2:0] TL_D_GRANT           = 3'h4;
  localparam logic [2:0] TL_D_GRANT_DATA      = 3'h5;
  localparam logic [2:0] TL_D_RELEASE_ACK     = 3'h6;

  typedef struct packed {
    logic [2:0]         opcode;
    logic [1:0]         param;
    logic [1:0]         size;
    logic [TL_SRCW-1:0] source;
    logic               sink;
    logic               denied;
    logic [TL_DW-1:0]   data;
    logic               corrupt;
  } tl_d_channel;

  // True for the opcodes whose beat carries a data payload.
  function automatic logic tl_d_has_data(input logic [2:0] op);
    return (op == TL_D_ACCESS_ACK_DATA) || (op == TL_D_GRANT_DATA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mpu_rsp_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module   : mpu_rsp_fifo_mem
//  Purpose  : Storage array for mpu_rsp_fifo. One synchronous write port,
//             one combinational read port. Contents are never reset.
//  Params   : DEPTH - number of entries (power of two)
//             T     - entry type
//  Ports    : clk   - clock
//             we    - write enable
//             waddr - write index
//             wdata - write data
//             raddr - read index
//             rdata - read data (combinational)
//  Revision : 1.0  initial release
// ============================================================================
module mpu_rsp_fifo_mem #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  T                         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output T                         rdata
);

  T r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/mpu_rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : mpu_rsp_fifo
//  Purpose  : Response FIFO for TL-D beats with occupancy count,
//             almost_full flag, high-water mark and synchronous flush.
//  Macro    : MPU_RSPFIFO_BYPASS_EN - when defined, an empty FIFO forwards
//             in_req straight to out_req if the consumer is ready.
//  Params   : DEPTH     - entry count (power of two, >= 2)
//             AF_THRESH - almost_full threshold (1..DEPTH)
//  Ports    : clk, rst (async, active high), flush (sync discard)
//             in_valid/in_ready/in_req    - producer side
//             out_valid/out_ready/out_req - consumer side
//             count       - current occupancy
//             almost_full - count >= AF_THRESH
//             hwm         - peak count since reset or flush
//  Revision : 1.0  initial release
// ============================================================================
module mpu_rsp_fifo
  import mpu_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  tl_d_channel                in_req,
  output logic                       out_valid,
  input  logic                       out_ready,
  output tl_d_channel                out_req,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output logic [$clog2(DEPTH+1)-1:0] hwm
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = $clog2(DEPTH+1);
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);
  localparam logic [c_CW-1:0] c_AF   = c_CW'(AF_THRESH);
  localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

  // Parameter legality, caught at elaboration.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
    $error("mpu_rsp_fifo: DEPTH must be a power of two and at least 2");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_chk_af
    $error("mpu_rsp_fifo: AF_THRESH must be within 1..DEPTH");
  end

  logic [c_CW-1:0] r_count;
  logic [c_CW-1:0] r_hwm;
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;

  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_wr_en;   // push that lands in storage
  logic            w_rd_en;   // pop that consumes a stored entry
  logic [c_CW-1:0] w_count_nxt;
  logic [c_CW-1:0] w_hwm_nxt;
  tl_d_channel     w_rdata;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_FULL);

  // Ready depends only on state and flush, never on out_ready, so a full
  // FIFO stalls one cycle before a simultaneous push/pop can occur.
  assign in_ready = !w_full && !flush;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

`ifdef MPU_RSPFIFO_BYPASS_EN
  logic w_bypass;

  // Beat goes straight through; it never touches storage or the counters.
  assign w_bypass  = w_empty && in_valid && out_ready && !flush;
  assign out_valid = !w_empty || w_bypass;

  always_comb begin
    out_req = '0;
    if (!w_empty) begin
      out_req = w_rdata;
    end else if (w_bypass) begin
      out_req = in_req;
    end
  end

  assign w_wr_en = w_push && !w_bypass;
  assign w_rd_en = w_pop && !w_bypass && !flush;
`else
  assign out_valid = !w_empty;
  assign out_req   = w_empty ? tl_d_channel'('0) : w_rdata;
  assign w_wr_en   = w_push;
  // Flush wins over a pop in the same cycle.
  assign w_rd_en   = w_pop && !flush;
`endif

  // Next occupancy and high-water mark.
  always_comb begin
    w_count_nxt = r_count;
    if (flush) begin
      w_count_nxt = '0;
    end else begin
      case ({w_wr_en, w_rd_en})
        2'b10:   w_count_nxt = r_count + c_ONE;
        2'b01:   w_count_nxt = r_count - c_ONE;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_comb begin
    w_hwm_nxt = r_hwm;
    if (flush) begin
      w_hwm_nxt = '0;
    end else if (w_count_nxt > r_hwm) begin
      w_hwm_nxt = w_count_nxt;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_hwm    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_hwm   <= w_hwm_nxt;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr_en) begin
          r_wr_ptr <= r_wr_ptr + c_AW'(1);
        end
        if (w_rd_en) begin
          r_rd_ptr <= r_rd_ptr + c_AW'(1);
        end
      end
    end
  end

  mpu_rsp_fifo_mem #(
    .DEPTH (DEPTH),
    .T     (tl_d_channel)
  ) u_mem (
    .clk   (clk),
    .we    (w_wr_en),
    .waddr (r_wr_ptr),
    .wdata (in_req),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

  assign count       = r_count;
  assign hwm         = r_hwm;
  assign almost_full = (r_count >= c_AF);

endmodule
`default_nettype wire

// File: tb/tb_mpu_rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mpu_rsp_fifo
//  Purpose  : Directed self-checking bench for mpu_rsp_fifo (DEPTH=4,
//             AF_THRESH=3). Honors MPU_RSPFIFO_BYPASS_EN for the bypass case.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mpu_rsp_fifo;
  import mpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  tl_d_channel in_req;
  logic        out_valid;
  logic        out_ready;
  tl_d_channel out_req;
  logic [2:0]  count;
  logic        almost_full;
  logic [2:0]  hwm;

  int n_checks;
  int n_fail;

  mpu_rsp_fifo #(
    .DEPTH     (4),
    .AF_THRESH (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_req      (in_req),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_req     (out_req),
    .count       (count),
    .almost_full (almost_full),
    .hwm         (hwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic tl_d_channel mk(input logic [7:0] src, input logic [31:0] d);
    tl_d_channel b;
    b        = '0;
    b.opcode = TL_D_ACCESS_ACK_DATA;
    b.size   = 2'd2;
    b.source = src;
    b.data   = d;
    return b;
  endfunction

  // Advance past the next rising edge; inputs are then driven and outputs
  // sampled well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_req = '0;
    #3;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (out_req !== tl_d_channel'('0)) begin n_fail++; $display("FAIL rst_out_req got=%h exp=0", out_req); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL rst_almost_full got=%b exp=0", almost_full); end
    n_checks++; if (hwm !== 3'd0) begin n_fail++; $display("FAIL rst_hwm got=%0d exp=0", hwm); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fill_drain();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_req   = mk(8'(i), 32'h100 + 32'(i));
      tick();
      n_checks++; if (count !== 3'(i)) begin n_fail++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i); end
      n_checks++; if (almost_full !== (i >= 3)) begin n_fail++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, almost_full, (i >= 3)); end
      n_checks++; if (in_ready !== (i < 4)) begin n_fail++; $display("FAIL fill_in_ready[%0d] got=%b exp=%b", i, in_ready, (i < 4)); end
    end
    in_valid = 1'b0;
    n_checks++; if (hwm !== 3'd4) begin n_fail++; $display("FAIL fill_hwm got=%0d exp=4", hwm); end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d] got=%b exp=1", i, out_valid); end
      n_checks++; if (out_req.source !== 8'(i) || out_req.data !== 32'h100 + 32'(i)) begin
        n_fail++; $display("FAIL drain_order[%0d] got=%0d/%h exp=%0d/%h", i, out_req.source, out_req.data, i, 32'h100 + 32'(i));
      end
      tick();
    end
    out_ready = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL drain_count got=%0d exp=0", count); end
    n_checks++; if (out_valid !== 1'b0 || out_req !== tl_d_channel'('0)) begin
      n_fail++; $display("FAIL drain_empty got=%b/%h exp=0/0", out_valid, out_req);
    end
  endtask

  task automatic test_full_simul();
    out_ready = 1'b0;
    for (int i = 5; i <= 8; i++) begin
      in_valid = 1'b1;
      in_req   = mk(8'(i), 32'h200 + 32'(i));
      tick();
    end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count got=%0d exp=4", count); end
    in_req    = mk(8'd9, 32'h209);
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
    n_checks++; if (out_req.source !== 8'd5) begin n_fail++; $display("FAIL full_head got=%0d exp=5", out_req.source); end
    tick();
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_pop_only got=%0d exp=3", count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_back got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_push_pop got=%0d exp=3", count); end
    for (int i = 7; i <= 9; i++) begin
      #1;
      n_checks++; if (out_req.source !== 8'(i)) begin n_fail++; $display("FAIL full_order[%0d] got=%0d exp=%0d", i, out_req.source, i); end
      tick();
    end
    out_ready = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL full_drained got=%0d exp=0", count); end
  endtask

  task automatic test_wrap();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_req    = mk(8'd20, 32'h3000_0014);
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_req = mk(8'(21 + k), 32'h3000_0000 + 32'(21 + k));
      #1;
      n_checks++; if (out_req.source !== 8'(20 + k) || out_req.data !== 32'h3000_0000 + 32'(20 + k)) begin
        n_fail++; $display("FAIL wrap_order[%0d] got=%0d/%h exp=%0d", k, out_req.source, out_req.data, 20 + k);
      end
      tick();
      n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL wrap_count[%0d] got=%0d exp=1", k, count); end
    end
    in_valid = 1'b0;
    #1;
    n_checks++; if (out_req.source !== 8'd30) begin n_fail++; $display("FAIL wrap_last got=%0d exp=30", out_req.source); end
    tick();
    out_ready = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL wrap_empty got=%0d exp=0", count); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_req   = mk(8'(33 + i), 32'h4000_0000 + 32'(i));
      tick();
    end
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_pre got=%0d exp=3", count); end
    flush     = 1'b1;
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count got=%0d exp=0", count); end
    n_checks++; if (hwm !== 3'd0) begin n_fail++; $display("FAIL flush_hwm got=%0d exp=0", hwm); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    in_valid = 1'b1;
    in_req   = mk(8'd40, 32'h4000_0040);
    tick();
    in_valid = 1'b0;
    n_checks++; if (count !== 3'd1 || hwm !== 3'd1) begin n_fail++; $display("FAIL flush_repush got=%0d/%0d exp=1/1", count, hwm); end
    n_checks++; if (out_req.source !== 8'd40) begin n_fail++; $display("FAIL flush_head got=%0d exp=40", out_req.source); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_drain got=%0d exp=0", count); end
  endtask

  task automatic test_bypass();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_req    = mk(8'd60, 32'hCAFE_0001);
    #1;
`ifdef MPU_RSPFIFO_BYPASS_EN
    n_checks++; if (out_valid !== 1'b1 || out_req.data !== 32'hCAFE_0001) begin
      n_fail++; $display("FAIL byp_same got=%b/%h exp=1/cafe0001", out_valid, out_req.data);
    end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++; if (count !== 3'd0 || hwm !== 3'd1) begin n_fail++; $display("FAIL byp_count got=%0d/%0d exp=0/1", count, hwm); end
`else
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL byp_none got=%b exp=0", out_valid); end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b1 || count !== 3'd1 || out_req.data !== 32'hCAFE_0001) begin
      n_fail++; $display("FAIL byp_next got=%b/%0d/%h exp=1/1/cafe0001", out_valid, count, out_req.data);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL byp_drain got=%0d exp=0", count); end
`endif
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_req   = mk(8'(45 + i), 32'h5000_0000 + 32'(i));
      tick();
    end
    in_valid = 1'b0;
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL mid_pre got=%0d exp=2", count); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (count !== 3'd0 || hwm !== 3'd0) begin n_fail++; $display("FAIL mid_count got=%0d/%0d exp=0/0", count, hwm); end
    n_checks++; if (out_valid !== 1'b0 || out_req !== tl_d_channel'('0)) begin
      n_fail++; $display("FAIL mid_out got=%b/%h exp=0/0", out_valid, out_req);
    end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
    #1 rst = 1'b0;
    tick();
    n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_after got=%0d/%b exp=0/0", count, out_valid); end
    in_valid = 1'b1;
    in_req   = mk(8'd50, 32'h5000_0050);
    tick();
    in_valid = 1'b0;
    n_checks++; if (count !== 3'd1 || out_req.source !== 8'd50) begin
      n_fail++; $display("FAIL mid_repush got=%0d/%0d exp=1/50", count, out_req.source);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_fill_drain();
    test_full_simul();
    test_wrap();
    test_flush();
    test_bypass();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
